// File: rtl/alu_issue_ctrl.sv
// Issue controller for the combinational ALU: latches one instruction, reads
// operands from a 16-entry register file, captures the ALU result and writes it back.
module alu_issue_ctrl #(
    parameter int              DW       = 32,
    parameter logic [DW-1:0]   RF_RESET = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [31:0]   instr,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [3:0]    alu_opcode,
    input  logic [DW-1:0] alu_result,
    output logic          done,
    output logic [DW-1:0] done_data,
    input  logic [3:0]    dbg_addr,
    output logic [DW-1:0] dbg_data
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

    state_t        state_q, state_d;
    logic [31:0]   instr_q;
    logic [DW-1:0] a_q, b_q, res_q;
    logic [3:0]    op_q;
    logic [DW-1:0] rf_q [0:15];

    logic [3:0]    func, rd, rs, rt;
    logic          imm_sel;
    logic [14:0]   imm15;
    logic [DW-1:0] imm_sext;

    assign func     = instr_q[31:28];
    assign imm_sel  = instr_q[27];
    assign rd       = instr_q[26:23];
    assign rs       = instr_q[22:19];
    assign rt       = instr_q[18:15];
    assign imm15    = instr_q[14:0];
    assign imm_sext = {{(DW-15){imm15[14]}}, imm15};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (instr_valid) state_d = S_READ;
            S_READ: state_d = S_EXEC;
            S_EXEC: state_d = S_WB;
            S_WB:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        instr_ready = (state_q == S_IDLE);
        done        = (state_q == S_WB);
        alu_a       = a_q;
        alu_b       = b_q;
        alu_opcode  = op_q;
        done_data   = res_q;
    end

    // Entry 0 is cleared on reset and never written, so plain indexing reads r0 as 0.
    always_comb begin
        dbg_data = rf_q[dbg_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            for (int unsigned i = 0; i < 16; i++) begin
                rf_q[i] <= (i == 0) ? '0 : RF_RESET;
            end
        end else begin
            case (state_q)
                S_IDLE: if (instr_valid) instr_q <= instr;
                S_READ: begin
                    a_q  <= rf_q[rs];
                    b_q  <= imm_sel ? imm_sext : rf_q[rt];
                    op_q <= func;
                end
                S_EXEC: res_q <= alu_result;
                S_WB:   if (rd != 4'd0) rf_q[rd] <= res_q;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed plan steps plus random
// instructions checked against an array-based register-file model.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] alu_a, alu_b, alu_result, done_data, dbg_data;
    logic [3:0]  alu_opcode, dbg_addr;
    logic        done;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned cyc   = 0;
    int unsigned last_accept = 0;
    bit          prev_hold = 1'b0;
    logic [31:0] m_rf [16];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [31:0] alu_f(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return ~a;
            4'd6:  return a << 1;
            4'd7:  return a >> 1;
            4'd8:  return a + 32'd1;
            4'd9:  return a - 32'd1;
            4'd10: return 32'($countones(a));
            4'd11: return {b[15:0], 16'h0};
            4'd12: return a << b[4:0];
            4'd13: return a >> b[4:0];
            4'd14: return 32'($signed(a) >>> b[4:0]);
            default: return (a < b) ? 32'd1 : 32'd0;
        endcase
    endfunction

    assign alu_result = alu_f(alu_opcode, alu_a, alu_b);

    alu_issue_ctrl #(.DW(32), .RF_RESET(32'h0)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_result(alu_result),
        .done(done), .done_data(done_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [3:0] f, input logic is, input logic [3:0] rd,
                                       input logic [3:0] rs, input logic [3:0] rt, input logic [14:0] im);
        return {f, is, rd, rs, rt, im};
    endfunction

    // Drives one instruction and walks it through READ/EXEC/WB, checking each cycle.
    task automatic issue(input logic [3:0] f, input logic is, input logic [3:0] rd, input logic [3:0] rs,
                         input logic [3:0] rt, input logic [14:0] im, input bit hold);
        logic [31:0] ea, eb, er;
        int unsigned n;
        ea = m_rf[rs];
        eb = is ? {{17{im[14]}}, im} : m_rf[rt];
        er = alu_f(f, ea, eb);
        instr       = mk(f, is, rd, rs, rt, im);
        instr_valid = 1'b1;
        n = 0;
        while (!instr_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (!instr_ready) chk("ready_timeout", {31'd0, instr_ready}, 32'd1);
        @(posedge clk); #1;
        if (prev_hold) chk("accept_gap", cyc - last_accept, 32'd4);
        last_accept = cyc;
        prev_hold   = hold;
        if (!hold) instr_valid = 1'b0;
        chk("read_ready", {31'd0, instr_ready}, 32'd0);
        chk("read_done",  {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        chk("exec_ready", {31'd0, instr_ready}, 32'd0);
        chk("exec_done",  {31'd0, done}, 32'd0);
        chk("exec_a",  alu_a, ea);
        chk("exec_b",  alu_b, eb);
        chk("exec_op", {28'd0, alu_opcode}, {28'd0, f});
        dbg_addr = rd;
        @(posedge clk); #1;
        chk("wb_ready", {31'd0, instr_ready}, 32'd0);
        chk("wb_done",  {31'd0, done}, 32'd1);
        chk("wb_data",  done_data, er);
        chk("wb_dbg_old", dbg_data, m_rf[rd]);
        @(posedge clk); #1;
        if (rd != 4'd0) m_rf[rd] = er;
        chk("idle_ready", {31'd0, instr_ready}, 32'd1);
        chk("idle_done",  {31'd0, done}, 32'd0);
        chk("idle_hold_data", done_data, er);
        chk("idle_dbg_new", dbg_data, m_rf[rd]);
    endtask

    initial begin
        rst = 1'b1; instr_valid = 1'b0; instr = '0; dbg_addr = '0;
        for (int i = 0; i < 16; i++) m_rf[i] = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_ready", {31'd0, instr_ready}, 32'd1);
        chk("rst_done",  {31'd0, done}, 32'd0);
        chk("rst_done_data", done_data, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        for (int i = 0; i < 16; i++) begin
            dbg_addr = 4'(i); #1;
            chk("rst_rf", dbg_data, 32'd0);
        end

        issue(4'd0, 1'b1, 4'd1, 4'd0, 4'd0, 15'd5, 1'b0);
        issue(4'd0, 1'b1, 4'd2, 4'd1, 4'd0, 15'h7FFF, 1'b0);
        chk("r2_is_4", m_rf[2], 32'd4);
        issue(4'd1, 1'b0, 4'd3, 4'd1, 4'd2, 15'd0, 1'b1);
        issue(4'd4, 1'b0, 4'd4, 4'd3, 4'd1, 15'd0, 1'b0);
        dbg_addr = 4'd3; #1 chk("raw_r3", dbg_data, 32'd1);
        dbg_addr = 4'd4; #1 chk("raw_r4", dbg_data, 32'd4);
        issue(4'd0, 1'b1, 4'd0, 4'd0, 4'd0, 15'd7, 1'b0);
        dbg_addr = 4'd0; #1 chk("r0_zero", dbg_data, 32'd0);

        for (int k = 0; k < 40; k++) begin
            issue(4'($urandom_range(15)), 1'($urandom_range(1)), 4'($urandom_range(15)),
                  4'($urandom_range(15)), 4'($urandom_range(15)), 15'($urandom), bit'($urandom_range(1)));
        end
        instr_valid = 1'b0;
        prev_hold   = 1'b0;
        @(posedge clk); #1;

        // Reset during EXEC of a write to r5.
        instr = mk(4'd0, 1'b1, 4'd5, 4'd0, 4'd0, 15'd9);
        instr_valid = 1'b1;
        @(posedge clk); #1 instr_valid = 1'b0;
        @(posedge clk); #1 chk("mid_exec_b", alu_b, 32'd9);
        rst = 1'b1; #1;
        for (int i = 0; i < 16; i++) m_rf[i] = '0;
        chk("mid_rst_ready", {31'd0, instr_ready}, 32'd1);
        chk("mid_rst_done",  {31'd0, done}, 32'd0);
        chk("mid_rst_data",  done_data, 32'd0);
        chk("mid_rst_a",     alu_a, 32'd0);
        chk("mid_rst_b",     alu_b, 32'd0);
        chk("mid_rst_op",    {28'd0, alu_opcode}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1 chk("mid_no_done", {31'd0, done}, 32'd0);
        end
        dbg_addr = 4'd5; #1 chk("mid_r5", dbg_data, 32'd0);
        dbg_addr = 4'd1; #1 chk("mid_r1", dbg_data, 32'd0);
        issue(4'd8, 1'b0, 4'd6, 4'd0, 4'd0, 15'd0, 1'b0);
        dbg_addr = 4'd6; #1 chk("post_rst_r6", dbg_data, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
